top_fdct_mac_pipe: RTL

Parametrised, pipelined signed multiply-accumulate unit for the fdct datapath. It generalises the combinational 16s x 14s -> 29 multiplier with several additions:
- configurable operand and result widths
- configurable pipeline depth
- valid/ready flow control with backpressure
- a per-beat accumulate mode for dot-product terms

It sits between the coefficient/sample fetch logic and the DCT output stage.

---
 rtl/top_fdct_mac_pipe.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/top_fdct_mac_pipe.sv
// Pipelined signed multiply-accumulate for the fdct datapath, with valid/ready flow control.
// Define SATURATE_EN to clamp dout into DOUT_WIDTH and flag overflow on sat; otherwise dout wraps.
module top_fdct_mac_pipe #(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 14,
  parameter int unsigned DOUT_WIDTH = 29,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned ACC_GUARD  = 4
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_acc,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_last,
  output logic                         sat
);

  localparam int unsigned PROD_W = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned SUM_W  = PROD_W + ACC_GUARD;

  logic                     en;
  logic                     fin_valid;
  logic                     fin_acc;
  logic                     fin_last;
  logic signed [PROD_W-1:0] fin_prod;

  logic signed [SUM_W-1:0]      acc_q;
  logic signed [SUM_W-1:0]      prod_ext;
  logic signed [SUM_W-1:0]      acc_sel;
  logic signed [SUM_W-1:0]      sum_c;
  logic signed [DOUT_WIDTH-1:0] dout_d;
  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic                         sat_d;
  logic                         sat_q;
  logic                         out_valid_q;
  logic                         out_last_q;

  // Whole pipeline advances in lockstep; a bubble at the output never blocks.
  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign fin_valid = in_valid;
      assign fin_acc   = in_acc;
      assign fin_last  = in_last;
      assign fin_prod  = PROD_W'(din0) * PROD_W'(din1);
    end else begin : g_pipe
      logic                         s1_valid_q;
      logic                         s1_acc_q;
      logic                         s1_last_q;
      logic signed [DIN0_WIDTH-1:0] s1_a_q;
      logic signed [DIN1_WIDTH-1:0] s1_b_q;
      logic signed [PROD_W-1:0]     s1_prod;

      // Operand capture stage.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          s1_valid_q <= 1'b0;
          s1_acc_q   <= 1'b0;
          s1_last_q  <= 1'b0;
          s1_a_q     <= '0;
          s1_b_q     <= '0;
        end else if (en) begin
          s1_valid_q <= in_valid;
          if (in_valid) begin
            s1_acc_q  <= in_acc;
            s1_last_q <= in_last;
            s1_a_q    <= din0;
            s1_b_q    <= din1;
          end
        end
      end

      assign s1_prod = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);

      if (NUM_STAGE == 2) begin : g_direct
        assign fin_valid = s1_valid_q;
        assign fin_acc   = s1_acc_q;
        assign fin_last  = s1_last_q;
        assign fin_prod  = s1_prod;
      end else begin : g_mid
        localparam int unsigned MID_N = NUM_STAGE - 2;
        logic                     mid_valid_q [MID_N];
        logic                     mid_acc_q   [MID_N];
        logic                     mid_last_q  [MID_N];
        logic signed [PROD_W-1:0] mid_prod_q  [MID_N];

        // Product delay line; retiming may move the multiplier across these registers.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
          if (!ap_rst_n) begin
            for (int i = 0; i < int'(MID_N); i++) begin
              mid_valid_q[i] <= 1'b0;
              mid_acc_q[i]   <= 1'b0;
              mid_last_q[i]  <= 1'b0;
              mid_prod_q[i]  <= '0;
            end
          end else if (en) begin
            mid_valid_q[0] <= s1_valid_q;
            if (s1_valid_q) begin
              mid_acc_q[0]  <= s1_acc_q;
              mid_last_q[0] <= s1_last_q;
              mid_prod_q[0] <= s1_prod;
            end
            for (int i = 1; i < int'(MID_N); i++) begin
              mid_valid_q[i] <= mid_valid_q[i-1];
              if (mid_valid_q[i-1]) begin
                mid_acc_q[i]  <= mid_acc_q[i-1];
                mid_last_q[i] <= mid_last_q[i-1];
                mid_prod_q[i] <= mid_prod_q[i-1];
              end
            end
          end
        end

        assign fin_valid = mid_valid_q[MID_N-1];
        assign fin_acc   = mid_acc_q[MID_N-1];
        assign fin_last  = mid_last_q[MID_N-1];
        assign fin_prod  = mid_prod_q[MID_N-1];
      end
    end
  endgenerate

  assign prod_ext = SUM_W'(fin_prod);
  assign acc_sel  = fin_acc ? acc_q : '0;
  assign sum_c    = acc_sel + prod_ext;

`ifdef SATURATE_EN
  localparam int unsigned EXT_W = (SUM_W > DOUT_WIDTH) ? SUM_W : DOUT_WIDTH;
  logic signed [EXT_W-1:0] sum_ext;

  // Overflow when the bits above the dout sign bit disagree with the sum's sign.
  always_comb begin
    sum_ext = EXT_W'(sum_c);
    dout_d  = DOUT_WIDTH'(sum_ext);
    sat_d   = 1'b0;
    if (sum_ext[EXT_W-1:DOUT_WIDTH-1] != {(EXT_W-DOUT_WIDTH+1){sum_ext[EXT_W-1]}}) begin
      sat_d  = 1'b1;
      dout_d = sum_ext[EXT_W-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
  end
`else
  assign dout_d = DOUT_WIDTH'(sum_c);
  assign sat_d  = 1'b0;
`endif

  // Output register; acc_q tracks the full-width sum of every beat that lands here.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      dout_q      <= '0;
      acc_q       <= '0;
    end else if (en) begin
      out_valid_q <= fin_valid;
      if (fin_valid) begin
        out_last_q <= fin_last;
        sat_q      <= sat_d;
        dout_q     <= dout_d;
        acc_q      <= sum_c;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sat       = sat_q;
  assign dout      = dout_q;

endmodule
